// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter.
// Also imported by the multicycle core controller.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

    localparam int LAT_DEFAULT = 2;
    localparam int CNT_W       = 4;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin selector: on a tie the requester that was not
// served last wins.
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic grant_valid,
    output logic grant_idx
);

    always_comb begin
        grant_valid = req0 | req1;
        grant_idx   = REQ_CPU;
        if (req0 && req1) begin
            grant_idx = ~last;
        end else if (req1) begin
            grant_idx = REQ_LDR;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter and sequencer for the single-port unified memory of the
// multicycle MIPS core: CPU (0) and loader/DMA (1) share one port.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LAT = LAT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          done0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LAT);

    arb_state_t       state;
    arb_state_t       state_nx;
    logic             owner;
    logic             owner_nx;
    logic             last;
    logic             last_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             lat_we;
    logic             lat_we_nx;
    logic [AW-1:0]    lat_addr;
    logic [AW-1:0]    lat_addr_nx;
    logic [DW-1:0]    lat_wdata;
    logic [DW-1:0]    lat_wdata_nx;
    logic [DW-1:0]    rdata_q;
    logic [DW-1:0]    rdata_nx;

    logic pick_req0;
    logic pick_req1;
    logic grant_valid;
    logic grant_idx;
    logic take;

    // In DONE the finishing owner still holds req; only the other side may win.
    always_comb begin
        pick_req0 = req0;
        pick_req1 = req1;
        if (state == ST_DONE) begin
            pick_req0 = req0 & (owner != REQ_CPU);
            pick_req1 = req1 & (owner != REQ_LDR);
        end
    end

    rr_pick2 u_pick (
        .req0        (pick_req0),
        .req1        (pick_req1),
        .last        (last),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            owner     <= REQ_CPU;
            last      <= REQ_LDR;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            state     <= state_nx;
            owner     <= owner_nx;
            last      <= last_nx;
            cnt       <= cnt_nx;
            lat_we    <= lat_we_nx;
            lat_addr  <= lat_addr_nx;
            lat_wdata <= lat_wdata_nx;
            rdata_q   <= rdata_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        owner_nx     = owner;
        last_nx      = last;
        cnt_nx       = cnt;
        lat_we_nx    = lat_we;
        lat_addr_nx  = lat_addr;
        lat_wdata_nx = lat_wdata;
        rdata_nx     = rdata_q;
        take         = 1'b0;

        unique case (state)
            ST_IDLE: begin
                take = grant_valid;
            end
            ST_ISSUE: begin
                cnt_nx   = LAT_CNT;
                state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_nx = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    if (!lat_we) begin
                        rdata_nx = mem_rdata;
                    end
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                last_nx  = owner;
                state_nx = ST_IDLE;
                take     = grant_valid;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // Grant: snapshot the winner so later request changes are harmless.
        if (take) begin
            owner_nx     = grant_idx;
            lat_we_nx    = grant_idx ? we1 : we0;
            lat_addr_nx  = grant_idx ? addr1 : addr0;
            lat_wdata_nx = grant_idx ? wdata1 : wdata0;
            state_nx     = ST_ISSUE;
        end
    end

    assign busy      = (state != ST_IDLE);
    assign mem_en    = (state == ST_ISSUE);
    assign done0     = (state == ST_DONE) && (owner == REQ_CPU);
    assign done1     = (state == ST_DONE) && (owner == REQ_LDR);
    assign mem_we    = lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three latency variants driven in turn,
// checked against a deadline-based transaction model.
module tb_mem_arbiter;

    localparam int NDUT = 3;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 4;
    endfunction

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1, mem_rdata;

    logic [NDUT-1:0] done0_v, done1_v, busy_v, mem_en_v, mem_we_v;
    logic [31:0]     rdata_v[NDUT];
    logic [31:0]     mem_addr_v[NDUT];
    logic [31:0]     mem_wdata_v[NDUT];

    always #5 clk = ~clk;

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        mem_arbiter #(.AW(32), .DW(32), .LAT(lat_of(k))) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req0      (req0),
            .we0       (we0),
            .addr0     (addr0),
            .wdata0    (wdata0),
            .done0     (done0_v[k]),
            .req1      (req1),
            .we1       (we1),
            .addr1     (addr1),
            .wdata1    (wdata1),
            .done1     (done1_v[k]),
            .rdata     (rdata_v[k]),
            .busy      (busy_v[k]),
            .mem_en    (mem_en_v[k]),
            .mem_we    (mem_we_v[k]),
            .mem_addr  (mem_addr_v[k]),
            .mem_wdata (mem_wdata_v[k]),
            .mem_rdata (mem_rdata)
        );
    end

    int n_vec, n_err;
    int sel, lat, cyc;

    // Transaction model: a grant at cycle g issues at g+1, completes at g+LAT+2.
    bit          m_busy, m_owner, m_last, m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;
    int          m_g;
    bit          e_done[2];
    bit          pend[2], rq[2], drop_nxt[2];
    int          dcnt_dut[2], dcnt_mdl[2];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (lat %0d cyc %0d)",
                   tag, obs, exp, lat, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_last  = 1;
        m_we    = 0;
        m_addr  = '0;
        m_wdata = '0;
        m_rdata = '0;
        m_g     = 0;
        cyc     = 0;
        for (int i = 0; i < 2; i++) begin
            pend[i]     = 0;
            rq[i]       = 0;
            drop_nxt[i] = 0;
            e_done[i]   = 0;
            dcnt_dut[i] = 0;
            dcnt_mdl[i] = 0;
        end
    endtask

    task automatic grant(input bit i);
        m_busy  = 1;
        m_owner = i;
        m_g     = cyc;
        m_we    = i ? we1 : we0;
        m_addr  = i ? addr1 : addr0;
        m_wdata = i ? wdata1 : wdata0;
    endtask

    task automatic check_now();
        bit en, dn;
        en = m_busy && (cyc == m_g + 1);
        dn = m_busy && (cyc == m_g + lat + 2);
        e_done[0] = dn && !m_owner;
        e_done[1] = dn && m_owner;
        chk("busy", busy_v[sel], m_busy);
        chk("mem_en", mem_en_v[sel], en);
        chk("mem_we", mem_we_v[sel], m_we);
        chk("mem_addr", mem_addr_v[sel], m_addr);
        chk("mem_wdata", mem_wdata_v[sel], m_wdata);
        chk("done0", done0_v[sel], e_done[0]);
        chk("done1", done1_v[sel], e_done[1]);
        chk("rdata", rdata_v[sel], m_rdata);
        dcnt_dut[0] += int'(done0_v[sel]);
        dcnt_dut[1] += int'(done1_v[sel]);
    endtask

    task automatic model_advance();
        bit r[2];
        r[0] = req0;
        r[1] = req1;
        if (m_busy && cyc == m_g + lat + 2) begin
            m_last = m_owner;
            drop_nxt[m_owner] = 1;
            dcnt_mdl[m_owner]++;
            if (r[!m_owner]) grant(!m_owner);
            else m_busy = 0;
        end else if (m_busy) begin
            if (cyc == m_g + lat + 1 && !m_we) m_rdata = mem_rdata;
        end else if (r[0] || r[1]) begin
            grant((r[0] && r[1]) ? !m_last : r[1]);
        end
    endtask

    task automatic new_fields(input int i);
        logic [31:0] a;
        a = $urandom & 32'hffff_fffc;
        if (i == 0) begin
            we0 = 1'($urandom_range(1)); addr0 = a; wdata0 = $urandom;
        end else begin
            we1 = 1'($urandom_range(1)); addr1 = a; wdata1 = $urandom;
        end
    endtask

    // Requesters hold req until done, drop it the cycle after, may
    // abandon it after the grant, and scramble fields once granted.
    task automatic gen_stim(input int pct, input bit allow_drop);
        for (int i = 0; i < 2; i++) begin
            if (drop_nxt[i]) begin
                rq[i] = 0; pend[i] = 0; drop_nxt[i] = 0;
                new_fields(i);
            end else if (!pend[i]) begin
                new_fields(i);
                if (int'($urandom_range(99)) < pct) begin
                    pend[i] = 1; rq[i] = 1;
                end
            end else if (m_busy && m_owner == i) begin
                new_fields(i);
                if (allow_drop && $urandom_range(7) == 0) rq[i] = 0;
            end
        end
        req0 = rq[0];
        req1 = rq[1];
        mem_rdata = $urandom;
    endtask

    task automatic step(input bit rnd, input int pct, input bit allow_drop);
        check_now();
        if (rnd) gen_stim(pct, allow_drop);
        model_advance();
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input int k);
        sel = k;
        lat = lat_of(k);
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        mem_rdata = '0;
        @(negedge clk);
        reset = 1;
        #1;
        model_reset();
        chk("rst_busy", busy_v[sel], 1'b0);
        chk("rst_mem_en", mem_en_v[sel], 1'b0);
        chk("rst_mem_we", mem_we_v[sel], 1'b0);
        chk("rst_done0", done0_v[sel], 1'b0);
        chk("rst_done1", done1_v[sel], 1'b0);
        chk("rst_rdata", rdata_v[sel], 32'h0);
        chk("rst_mem_addr", mem_addr_v[sel], 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic single(input bit i, input bit we, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] rd_base,
                          input bit vary);
        int start, seen;
        bit got;
        start = cyc;
        seen  = -1;
        got   = 0;
        if (i) begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
        else   begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
        for (int n = 0; n < 40; n++) begin
            mem_rdata = vary ? rd_base + 32'(cyc - start) : rd_base;
            if ((i ? done1_v[sel] : done0_v[sel]) === 1'b1 && seen < 0) seen = cyc;
            step(0, 0, 0);
            if (e_done[i]) begin
                got = 1;
                break;
            end
        end
        chk("xfer_done_seen", got, 1'b1);
        chk("xfer_latency", 32'(seen - start), 32'(lat + 2));
        if (i) req1 = 0; else req0 = 0;
        step(0, 0, 0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 0;

        // LAT=2: CPU read then write, rdata held across the write
        do_reset(1);
        single(0, 0, 32'h40, 32'h0, 32'hdead_beef, 0);
        chk("rd_rdata", rdata_v[1], 32'hdead_beef);
        chk("rd_idle", busy_v[1], 1'b0);
        single(0, 1, 32'h44, 32'h1234_5678, 32'h0bad_0bad, 0);
        chk("wr_rdata_hold", rdata_v[1], 32'hdead_beef);
        chk("wr_mem_wdata", mem_wdata_v[1], 32'h1234_5678);
        single(1, 0, 32'h100, 32'h0, 32'h0000_cafe, 0);
        chk("ldr_rdata", rdata_v[1], 32'h0000_cafe);

        // LAT=2: tie out of reset, then sustained contention
        do_reset(1);
        for (int n = 0; n < 60; n++) step(1, 100, 0);
        chk("cont_n0", dcnt_dut[0], 32'd7);
        chk("cont_n1", dcnt_dut[1], 32'd7);
        chk("cont_n0_mdl", dcnt_dut[0], dcnt_mdl[0]);

        // LAT=4: reset during ISSUE and during WAIT
        do_reset(2);
        req0 = 1; we0 = 0; addr0 = 32'h80; mem_rdata = 32'h5555_aaaa;
        step(0, 0, 0);
        chk("iss_en", mem_en_v[2], 1'b1);
        reset = 1;
        #1;
        chk("iss_rst_en", mem_en_v[2], 1'b0);
        chk("iss_rst_busy", busy_v[2], 1'b0);
        do_reset(2);
        req0 = 1; we0 = 0; addr0 = 32'h80; mem_rdata = 32'h5555_aaaa;
        step(0, 0, 0);
        step(0, 0, 0);
        chk("wait_busy", busy_v[2], 1'b1);
        reset = 1;
        #1;
        chk("wait_rst_busy", busy_v[2], 1'b0);
        chk("wait_rst_en", mem_en_v[2], 1'b0);
        chk("wait_rst_done0", done0_v[2], 1'b0);
        do_reset(2);
        single(0, 0, 32'h84, 32'h0, 32'h7777_0000, 1);
        chk("lat4_rdata", rdata_v[2], 32'h7777_0005);

        // LAT=1: one-cycle WAIT captures the cycle-2 memory data
        do_reset(0);
        single(0, 0, 32'h48, 32'h0, 32'ha5a5_0000, 1);
        chk("lat1_rdata", rdata_v[0], 32'ha5a5_0002);

        // Randomized traffic on every latency variant
        for (int k = 0; k < NDUT; k++) begin
            do_reset(k);
            for (int n = 0; n < 300; n++) step(1, 35, 1);
            chk("rnd_n0", dcnt_dut[0], dcnt_mdl[0]);
            chk("rnd_n1", dcnt_dut[1], dcnt_mdl[1]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
